// File: rtl/serdes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : serdes_pkg                                                |
// | Purpose  : Shared definitions for the serial transmitter/receiver    |
// |            pair: receive-side state encoding and default payload     |
// |            width.                                                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package serdes_pkg;

  // Default payload bits per frame
  localparam int unsigned c_data_w_default = 8;

  // Receive deframer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage : serdes_pkg
`default_nettype wire

// File: rtl/ser_rx_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ser_rx_deframer                                           |
// | Purpose  : Strobe-driven serial frame receiver. Frame format is      |
// |            start(0), DATA_W data bits LSB first, optional even       |
// |            parity bit, stop(1). Delivers payload with parity and     |
// |            framing error flags as a one-cycle valid pulse.           |
// | Ports    : clk        - clock, rising edge                           |
// |            rst_n      - asynchronous active-low reset                |
// |            ser_in     - serial line (idles high)                     |
// |            bit_en     - bit strobe; ser_in sampled only when high    |
// |            par_en     - parity bit present (latched at start bit)    |
// |            data_out   - last received payload, held between frames   |
// |            data_valid - one-cycle pulse when outputs update          |
// |            par_err    - parity mismatch, qualified by data_valid     |
// |            frame_err  - stop bit was 0, qualified by data_valid      |
// |            busy       - receiver not idle                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ser_rx_deframer
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_W = c_data_w_default
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_in,
  input  logic              bit_en,
  input  logic              par_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              par_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              par_err_q, par_err_d;
  logic              frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      perr_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      perr_q       <= perr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    perr_d       = perr_q;
    data_out_d   = data_out_q;
    // Valid and flags are pulses: they drop unless the stop strobe fires
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    frame_err_d  = 1'b0;

    if (bit_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!ser_in) begin
            state_d  = ST_DATA;
            cnt_d    = '0;
            shift_d  = '0;
            par_en_d = par_en;
            perr_d   = 1'b0;
          end
        end
        ST_DATA: begin
          // LSB arrives first, so new bits enter at the top and move down
          shift_d           = shift_q >> 1;
          shift_d[DATA_W-1] = ser_in;
          cnt_d             = cnt_q + CNT_W'(1);
          if (cnt_q == c_cnt_last) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          perr_d  = (ser_in != ^shift_q);
          state_d = ST_STOP;
        end
        ST_STOP: begin
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
          par_err_d    = perr_q & par_en_q;
          frame_err_d  = ~ser_in;
          // A low stop bit may be the start of a break: wait for the line
          // to return high before hunting for the next start bit
          state_d      = ser_in ? ST_IDLE : ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          if (ser_in) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule : ser_rx_deframer
`default_nettype wire

// File: tb/tb_ser_rx_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ser_rx_deframer                                        |
// | Purpose  : Directed self-checking bench for ser_rx_deframer.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ser_rx_deframer;

  logic       clk;
  logic       rst_n;
  logic       ser_in;
  logic       bit_en;
  logic       par_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       par_err;
  logic       frame_err;
  logic       busy;

  int n_checks;
  int n_errors;

  // Captured output pulses
  logic [7:0] q_data[$];
  logic       q_perr[$];
  logic       q_ferr[$];
  int         n_stray_flags;
  int         n_long_pulses;
  logic       prev_dv;

  ser_rx_deframer #(.DATA_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_in     (ser_in),
    .bit_en     (bit_en),
    .par_en     (par_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .par_err    (par_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dv = 1'b0;
    end else begin
      if (data_valid) begin
        q_data.push_back(data_out);
        q_perr.push_back(par_err);
        q_ferr.push_back(frame_err);
        if (prev_dv) n_long_pulses++;
      end else if (par_err || frame_err) begin
        n_stray_flags++;
      end
      prev_dv = data_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    ser_in = b;
    bit_en = 1'b1;
    @(posedge clk); #1;
    bit_en = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic stop, input int gap, input logic toggle);
    par_en = pe;
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) begin
      if (toggle) par_en = ~par_en;
      send_bit(d[i], gap);
    end
    if (pe) send_bit(pbit, gap);
    send_bit(stop, gap);
  endtask

  task automatic idle_cycles(input int n);
    ser_in = 1'b1;
    bit_en = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d,
                              input logic pe, input logic fe);
    idle_cycles(2);
    check({tag, "_npulse"}, q_data.size(), 1);
    if (q_data.size() > 0) begin
      check({tag, "_data"}, q_data.pop_front(), d);
      check({tag, "_perr"}, q_perr.pop_front(), pe);
      check({tag, "_ferr"}, q_ferr.pop_front(), fe);
    end
    q_data.delete();
    q_perr.delete();
    q_ferr.delete();
  endtask

  initial begin
    logic [9:0] raw;
    n_checks      = 0;
    n_errors      = 0;
    n_stray_flags = 0;
    n_long_pulses = 0;
    prev_dv       = 1'b0;
    rst_n  = 1'b0;
    ser_in = 1'b1;
    bit_en = 1'b0;
    par_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data_out, 8'h00);
    check("rst_dv", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {par_err, frame_err}, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Raw line sequence 0,1,0,1,0,0,1,0,1,1 with strobes every cycle
    raw = 10'b11_0100_1010;
    par_en = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(raw[i], 0);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0);
    check("a5_hold", data_out, 8'hA5);
    check("a5_idle_busy", busy, 0);

    // Even parity: 0x3C has four ones, correct parity bit is 0
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    expect_frame("p_ok", 8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    expect_frame("p_bad", 8'h3C, 1'b1, 1'b0);

    // Low stop bit followed by a held-low break
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    expect_frame("brk", 8'h81, 1'b0, 1'b1);
    check("brk_busy_wait", busy, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
    check("brk_busy_low", busy, 1);
    idle_cycles(2);
    check("brk_no_false", q_data.size(), 0);
    send_bit(1'b1, 0);
    check("brk_released", busy, 0);

    // Abort a frame with reset after four data bits
    par_en = 1'b0;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    check("abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_data", data_out, 8'h00);
    check("abort_busy0", busy, 0);
    check("abort_outs", {data_valid, par_err, frame_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    expect_frame("post_rst", 8'h5A, 1'b0, 1'b0);

    // Back-to-back frames, strobe every third cycle, no idle bit between
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    idle_cycles(2);
    check("b2b_npulse", q_data.size(), 2);
    if (q_data.size() == 2) begin
      check("b2b_first", q_data[0], 8'h01);
      check("b2b_second", q_data[1], 8'hFE);
      check("b2b_flags", {q_perr[0], q_ferr[0], q_perr[1], q_ferr[1]}, 0);
    end
    q_data.delete();
    q_perr.delete();
    q_ferr.delete();

    // par_en wiggles during data bits of a no-parity frame
    send_frame(8'h10, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    expect_frame("pe_toggle", 8'h10, 1'b0, 1'b0);
    check("pe_toggle_idle", busy, 0);

    check("stray_flags", n_stray_flags, 0);
    check("long_pulses", n_long_pulses, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ser_rx_deframer
`default_nettype wire

// File: doc/ser_rx_deframer.md
SER_RX_DEFRAMER -- requirements
Module: ser_rx_deframer

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 ser_in  input  1  serial line; idles high; frame is start(0), DATA_W data bits LSB first, optional even-parity bit, stop(1).
REQ-005 bit_en  input  1  bit strobe; ser_in is sampled only in cycles where bit_en=1.
REQ-006 par_en  input  1  parity-bit-present select; sampled with the start bit.
REQ-007 data_out  output  DATA_W  last received payload; holds until the next frame completes.
REQ-008 data_valid  output  1  one-cycle pulse: data_out and error flags updated.
REQ-009 par_err  output  1  parity mismatch on the frame; qualified by data_valid.
REQ-010 frame_err  output  1  stop bit sampled 0; qualified by data_valid.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE, DATA, PARITY, STOP, WAIT_HIGH.
REQ-013 IDLE: a strobe sampling ser_in=0 SHALL enter DATA, clear the bit counter, and latch par_en; a strobe sampling 1 SHALL keep IDLE.
REQ-014 DATA: each strobe SHALL shift ser_in into the shift register MSB (LSB-first assembly) and increment the counter; the DATA_W-th strobe SHALL go to PARITY if latched par_en=1, else STOP.
REQ-015 PARITY: the strobe SHALL compare ser_in against XOR of the DATA_W payload bits (even parity over data+parity); mismatch SHALL set an internal error bit; next state STOP.
REQ-016 STOP: the strobe SHALL go to IDLE if ser_in=1, else to WAIT_HIGH with frame error recorded.
REQ-017 WAIT_HIGH: SHALL ignore low samples; the first strobe sampling 1 SHALL go to IDLE (a held-low break never triggers a false start).
REQ-018 The cycle after the stop-bit strobe, data_out SHALL equal the payload and data_valid SHALL be 1 for exactly one cycle, with par_err/frame_err valid that cycle and 0 otherwise.
REQ-019 Frames with errors SHALL still deliver data_out and data_valid.
REQ-020 par_err SHALL be 0 when par_en was latched 0.
REQ-021 par_en changes mid-frame SHALL have no effect on the current frame.
REQ-022 Cycles with bit_en=0 SHALL change no state; strobes may be arbitrarily spaced, including every cycle.
REQ-023 Back-to-back: a start bit on the strobe immediately after a good stop bit SHALL be accepted.
REQ-024 The bit counter SHALL be $clog2(DATA_W+1) bits wide and never wrap within a frame.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, counter 0, shift register 0, data_out 0, data_valid 0, par_err 0, frame_err 0, busy 0, regardless of frame progress.
REQ-026 After rst_n deasserts, the first frame SHALL be received normally with no residue from an aborted frame.

Structure
REQ-027 State enumeration and DATA_W default SHALL live in shared package serdes_pkg for reuse by the transmitter side.
REQ-028 Single module; no sub-module is warranted.

Verification
REQ-029 par_en=0, bit_en every cycle, frame 0,1,0,1,0,0,1,0,1,1 -> data_out=0xA5, data_valid one pulse, par_err=0, frame_err=0.
REQ-030 par_en=1, payload 0x3C, parity 0 -> par_err=0; repeat with parity 1 -> par_err=1, data_out=0x3C.
REQ-031 Payload 0x81, stop bit 0, line held low 5 strobes then high -> frame_err=1 pulse, busy high through break, no second data_valid until a new start after the high.
REQ-032 rst_n low after 4 data bits of 0xFF, then frame 0x5A -> outputs 0 during reset, then data_out=0x5A, no errors.
REQ-033 bit_en every 3rd cycle, back-to-back frames 0x01 then 0xFE with no idle bit -> two data_valid pulses, values 0x01 then 0xFE.
REQ-034 par_en toggled during data bits of a par_en=0 frame of 0x10 -> frame decoded without parity bit, data_out=0x10.
